vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator for the console video path: next generation of the fixed 640x480 sync generator. Adds asynchronous active-low reset, a run enable, registered and mutually aligned outputs, and line/frame start strobes. Adds an optional integer pixel-repeat scaler that presents low-resolution logical coordinates (e.g. 320x240 on a 640x480 raster) to the tile/sprite fetch logic. Sits between the pixel clock domain root and the pixel pipeline / DAC output register.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, cycles
- H_SYNC, 96, hsync width, cycles
- H_BACK, 48, horizontal back porch, cycles
- H_POL, 1'b0, hsync active level
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BACK, 33, vertical back porch, lines
- V_POL, 1'b0, vsync active level
- H_W, 10, width of h_pos/x; must hold H_TOTAL-1
- V_W, 10, width of v_pos/y; must hold V_TOTAL-1
- H_SCALE, 2, raw pixels per logical pixel (>=1)
- V_SCALE, 2, raw lines per logical line (>=1)
- pixel_clock  in  1  pixel clock
- pixel_reset_n  in  1  asynchronous, active-low reset
- run  in  1  counters advance while high
- vga_horizontal_sync  out  1  registered hsync
- vga_vertical_sync  out  1  registered vsync
- h_pos  out  H_W  raw column of current output cycle
- v_pos  out  V_W  raw line of current output cycle
- visible_area  out  1  h_pos<H_VISIBLE && v_pos<V_VISIBLE
- x  out  H_W  logical column (valid when visible_area)
- y  out  V_W  logical line (valid when visible_area)
- pixel_tick  out  1  first raw cycle of each logical pixel in visible area
- line_start  out  1  pulse at h_pos==0
- frame_start  out  1  pulse at h_pos==0 && v_pos==0

## Operation
- H_TOTAL = sum of H params (800 default); V_TOTAL likewise (525).
- Stage 1: counters hc, vc. hc wraps H_TOTAL-1 -> 0; vc increments when hc wraps, and wraps V_TOTAL-1 -> 0 at that same cycle.
- Stage 2: all outputs registered from stage-1 state. Outputs are mutually aligned: every output describes the same raw position (h_pos, v_pos).
- hsync active for H_VISIBLE+H_FRONT <= h_pos < H_VISIBLE+H_FRONT+H_SYNC; vsync active likewise on v_pos; inactive = ~POL.
- Scaler: sub-counter hs counts 0..H_SCALE-1 across visible pixels, x increments on hs wrap, and x and hs clear at line end. vs/y behave the same per line, and clear at frame end. pixel_tick = visible && hs==0.
- run low: at next edge, hc=vc=0 and scaler counters cleared. Outputs show sync inactive, visible_area=0, pulses 0, positions 0. run rising: the first output cycle is h_pos=0,v_pos=0 with frame_start=line_start=1.
- Reset (any time, incl. mid-frame): all outputs and counters immediately go to 0 / sync inactive / strobes 0. Restart after release proceeds as for run rising.
- Elaboration error ($error / invalid generate) if H_W/V_W is too narrow or a SCALE is 0.

## Timing
- Latency: 1 cycle from counter state to outputs; there is no combinational path from run.
- First output cycle with frame_start=1: two edges after reset release, given run is high.
- Line period exactly H_TOTAL cycles; frame period exactly H_TOTAL*V_TOTAL cycles (420000 default).
- line_start and frame_start are one cycle wide and coincide on frame origin.
- Non-dividing SCALE: the last logical pixel/line is partial, and x/y never exceed floor((VISIBLE-1)/SCALE).

## Configuration
- VGA_TIMING_GEN_SCALE_EN defined: scaler built as above.
- Undefined: no scaler logic. x=h_pos, y=v_pos, pixel_tick=visible_area; H_SCALE/V_SCALE ignored.

## Structure
- Package vga_timing_pkg: default 640x480@60 timing constants and a total/sync-start/sync-end helper function shared with the pixel pipeline.
- Sub-module vga_axis_counter, instantiated once for H and once for V. Contains the counter, wrap, sync and visible decode, and the optional scale sub-counter; advance input.

## Test plan
- Reset: assert pixel_reset_n=0 mid-line -> hsync=vsync=1, visible_area=0, h_pos=v_pos=x=y=0, strobes 0 immediately.
- Defaults: hsync low exactly at h_pos 656..751 (96 cycles); line period 800; vsync low on v_pos 490..491; frame_start every 420000 cycles.
- Scaler on, 2x2: at h_pos 639/v_pos 479 -> x=319, y=239; pixel_tick on even h_pos only; x=0 again at next line_start.
- run dropped at h_pos 300, v_pos 100 for 5 cycles -> outputs idle next cycle. After re-assert: h_pos=0, v_pos=0, frame_start=1 one cycle later.
- Small raster H=4/1/2/1, V=3/1/1/1, H_SCALE=3 -> line period 8, frame 48 cycles, x sequence 0,0,0,1 over visible.
- Scaler macro undefined -> x==h_pos, y==v_pos, pixel_tick==visible_area every cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and the axis geometry helper used by
// the timing generator and the pixel pipeline.
package vga_timing_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    typedef enum logic [1:0] {
        AXIS_TOTAL,
        AXIS_SYNC_START,
        AXIS_SYNC_END
    } axis_point_e;

    // Landmark positions on one axis: sync occupies [SYNC_START, SYNC_END).
    function automatic int unsigned axis_point(input axis_point_e pt,
                                               input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        case (pt)
            AXIS_SYNC_START: return visible + front;
            AXIS_SYNC_END:   return visible + front + sync;
            default:         return visible + front + sync + back;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, sync/visible decode and, when
// VGA_TIMING_GEN_SCALE_EN is defined, the pixel-repeat sub-counter.
module vga_axis_counter import vga_timing_pkg::*; #(
    parameter int unsigned VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned FRONT   = VGA_H_FRONT,
    parameter int unsigned SYNC    = VGA_H_SYNC,
    parameter int unsigned BACK    = VGA_H_BACK,
    parameter logic        POL     = 1'b0,
    parameter int unsigned W       = 10,
    parameter int unsigned SCALE   = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         adv_i,
    output logic [W-1:0] pos_o,
    output logic         vis_o,
    output logic         sync_o,
    output logic [W-1:0] log_o,
    output logic         first_o,
    output logic         last_o
);

    localparam int unsigned TOTAL      = axis_point(AXIS_TOTAL, VISIBLE, FRONT, SYNC, BACK);
    localparam int unsigned SYNC_START = axis_point(AXIS_SYNC_START, VISIBLE, FRONT, SYNC, BACK);
    localparam int unsigned SYNC_END   = axis_point(AXIS_SYNC_END, VISIBLE, FRONT, SYNC, BACK);

    if (TOTAL > (32'd1 << W)) begin : g_width_err
        $error("vga_axis_counter: W=%0d cannot hold TOTAL-1=%0d", W, TOTAL - 1);
    end
    if (SCALE == 0) begin : g_scale_err
        $error("vga_axis_counter: SCALE must be >= 1");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         last;

    assign last = (32'(cnt_q) == TOTAL - 1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (adv_i)
            cnt_d = last ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign pos_o  = cnt_q;
    assign vis_o  = (32'(cnt_q) < VISIBLE);
    assign sync_o = (32'(cnt_q) >= SYNC_START && 32'(cnt_q) < SYNC_END) ? POL : ~POL;
    assign last_o = last;

`ifdef VGA_TIMING_GEN_SCALE_EN
    localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [SW-1:0] sub_q, sub_d;
    logic [W-1:0]  log_q, log_d;

    // Counting stops on the last visible position so the logical coordinate
    // never passes floor((VISIBLE-1)/SCALE), even for a partial last pixel.
    always_comb begin
        sub_d = sub_q;
        log_d = log_q;
        if (clr_i || (adv_i && last)) begin
            sub_d = '0;
            log_d = '0;
        end else if (adv_i && (32'(cnt_q) + 1 < VISIBLE)) begin
            if (32'(sub_q) == SCALE - 1) begin
                sub_d = '0;
                log_d = log_q + W'(1);
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sub_q <= '0;
            log_q <= '0;
        end else begin
            sub_q <= sub_d;
            log_q <= log_d;
        end
    end

    assign log_o   = log_q;
    assign first_o = (sub_q == '0);
`else
    assign log_o   = cnt_q;
    assign first_o = 1'b1;
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered, mutually aligned outputs.
// Optional pixel-repeat scaler enabled by defining VGA_TIMING_GEN_SCALE_EN.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter logic        H_POL     = 1'b0,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter logic        V_POL     = 1'b0,
    parameter int unsigned H_W       = 10,
    parameter int unsigned V_W       = 10,
    parameter int unsigned H_SCALE   = 2,
    parameter int unsigned V_SCALE   = 2
) (
    input  logic           pixel_clock,
    input  logic           pixel_reset_n,
    input  logic           run,
    output logic           vga_horizontal_sync,
    output logic           vga_vertical_sync,
    output logic [H_W-1:0] h_pos,
    output logic [V_W-1:0] v_pos,
    output logic           visible_area,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           pixel_tick,
    output logic           line_start,
    output logic           frame_start
);

    // act_q marks the counters as live: it is only set one edge after run is
    // seen high, so the first live output is always the frame origin.
    logic act_q;
    logic clr, h_adv, v_adv;

    logic [H_W-1:0] hc, h_log;
    logic [V_W-1:0] vc, v_log;
    logic           h_vis, h_sync, h_first, h_last;
    logic           v_vis, v_sync, v_first, v_last;

    assign clr   = ~run;
    assign h_adv = run & act_q;
    assign v_adv = h_adv & h_last;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_POL), .W(H_W), .SCALE(H_SCALE)
    ) u_h_axis (
        .clk_i  (pixel_clock),
        .rst_ni (pixel_reset_n),
        .clr_i  (clr),
        .adv_i  (h_adv),
        .pos_o  (hc),
        .vis_o  (h_vis),
        .sync_o (h_sync),
        .log_o  (h_log),
        .first_o(h_first),
        .last_o (h_last)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_POL), .W(V_W), .SCALE(V_SCALE)
    ) u_v_axis (
        .clk_i  (pixel_clock),
        .rst_ni (pixel_reset_n),
        .clr_i  (clr),
        .adv_i  (v_adv),
        .pos_o  (vc),
        .vis_o  (v_vis),
        .sync_o (v_sync),
        .log_o  (v_log),
        .first_o(v_first),
        .last_o (v_last)
    );

    logic unused_v;
    assign unused_v = v_first ^ v_last;

    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic [H_W-1:0] hpos_q, hpos_d, x_q, x_d;
    logic [V_W-1:0] vpos_q, vpos_d, y_q, y_d;
    logic           vis_q, vis_d, tick_q, tick_d, ls_q, ls_d, fs_q, fs_d;

    always_comb begin
        hsync_d = ~H_POL;
        vsync_d = ~V_POL;
        hpos_d  = '0;
        vpos_d  = '0;
        vis_d   = 1'b0;
        x_d     = '0;
        y_d     = '0;
        tick_d  = 1'b0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (h_adv) begin
            hsync_d = h_sync;
            vsync_d = v_sync;
            hpos_d  = hc;
            vpos_d  = vc;
            vis_d   = h_vis & v_vis;
            x_d     = h_log;
            y_d     = v_log;
            tick_d  = h_vis & v_vis & h_first;
            ls_d    = (hc == '0);
            fs_d    = (hc == '0) && (vc == '0);
        end
    end

    always_ff @(posedge pixel_clock or negedge pixel_reset_n) begin
        if (!pixel_reset_n) begin
            act_q   <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            hpos_q  <= '0;
            vpos_q  <= '0;
            vis_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            tick_q  <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            act_q   <= run;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            vis_q   <= vis_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tick_q  <= tick_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vga_horizontal_sync = hsync_q;
    assign vga_vertical_sync   = vsync_q;
    assign h_pos               = hpos_q;
    assign v_pos               = vpos_q;
    assign visible_area        = vis_q;
    assign x                   = x_q;
    assign y                   = y_q;
    assign pixel_tick          = tick_q;
    assign line_start          = ls_q;
    assign frame_start         = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised run/reset stimulus on a small raster, checked against a model that
// derives every output from the count of consecutive live cycles.
module tb_vga_timing_gen;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1, HT = HV + HF + HS + HB;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1, VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int H_SC = 3, V_SC = 2;
    localparam bit H_POL = 1'b1, V_POL = 1'b0;

    logic       clk, rst_n, run;
    logic       hs, vs, vis, tick, ls, fs;
    logic [2:0] h_pos, v_pos, x, y;

    int n_checks, n_errors;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_POL(H_POL),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_POL(V_POL),
        .H_W(3), .V_W(3), .H_SCALE(H_SC), .V_SCALE(V_SC)
    ) dut (
        .pixel_clock        (clk),
        .pixel_reset_n      (rst_n),
        .run                (run),
        .vga_horizontal_sync(hs),
        .vga_vertical_sync  (vs),
        .h_pos              (h_pos),
        .v_pos              (v_pos),
        .visible_area       (vis),
        .x                  (x),
        .y                  (y),
        .pixel_tick         (tick),
        .line_start         (ls),
        .frame_start        (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // pos = index of this live cycle within the frame; idle when !live.
    task automatic compare(input string ph, input bit live, input int pos);
        int h, v, ex, ey;
        bit ev, et;
        h  = live ? pos % HT : 0;
        v  = live ? pos / HT : 0;
        ev = live && h < HV && v < VV;
        check({ph, ":h_pos"}, h_pos, h);
        check({ph, ":v_pos"}, v_pos, v);
        check({ph, ":visible"}, vis, ev);
        check({ph, ":hsync"}, hs,
              (live && h >= HV + HF && h < HV + HF + HS) ? H_POL : !H_POL);
        check({ph, ":vsync"}, vs,
              (live && v >= VV + VF && v < VV + VF + VS) ? V_POL : !V_POL);
        check({ph, ":line_start"}, ls, live && h == 0);
        check({ph, ":frame_start"}, fs, live && pos == 0);
`ifdef VGA_TIMING_GEN_SCALE_EN
        ex = h / H_SC;
        ey = v / V_SC;
        et = ev && (h % H_SC == 0);
        if (ev || !live) begin
            check({ph, ":x"}, x, ex);
            check({ph, ":y"}, y, ey);
        end
`else
        ex = h;
        ey = v;
        et = ev;
        check({ph, ":x"}, x, ex);
        check({ph, ":y"}, y, ey);
`endif
        check({ph, ":pixel_tick"}, tick, et);
    endtask

    initial begin
        bit live, run_prev, did_rst;
        int pos, streak, hold;
        int last_ls, last_fs, hs_cnt, vs_cnt;
        string ph;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare("reset", 1'b0, 0);

        rst_n    = 1'b1;
        run      = 1'b1;
        run_prev = 1'b0;
        streak   = 0;
        pos      = 0;
        hold     = 0;
        did_rst  = 1'b0;
        last_ls  = -1;
        last_fs  = -1;
        hs_cnt   = 0;
        vs_cnt   = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            live = run && run_prev;
            if (live) begin
                pos = streak % FRAME;
                streak++;
            end else begin
                streak = 0;
            end
            run_prev = run;

            @(negedge clk);
            ph = (cyc < 150) ? "steady" : "random";
            compare(ph, live, pos);

            // Run is held high for the first 150 cycles: measure periods.
            if (cyc < 150) begin
                if (ls) begin
                    if (last_ls >= 0) begin
                        check("line_period", cyc - last_ls, HT);
                        check("hsync_width", hs_cnt, HS);
                    end
                    last_ls = cyc;
                    hs_cnt  = 0;
                end
                if (fs) begin
                    if (last_fs >= 0) begin
                        check("frame_period", cyc - last_fs, FRAME);
                        check("vsync_cycles", vs_cnt, VS * HT);
                    end
                    last_fs = cyc;
                    vs_cnt  = 0;
                end
                if (hs == H_POL) hs_cnt++;
                if (vs == V_POL) vs_cnt++;
                continue;
            end

            // Asynchronous reset once, mid-line, then restart.
            if (!did_rst && cyc >= 600 && live && pos % HT == 3) begin
                did_rst = 1'b1;
                #2 rst_n = 1'b0;
                #1 compare("async_reset", 1'b0, 0);
                @(posedge clk);
                @(negedge clk);
                compare("in_reset", 1'b0, 0);
                rst_n    = 1'b1;
                run      = 1'b1;
                run_prev = 1'b0;
                streak   = 0;
                hold     = 20;
                continue;
            end

            if (hold == 0) begin
                run  = ($urandom_range(0, 3) != 0);
                hold = run ? $urandom_range(1, 60) : $urandom_range(1, 6);
            end
            hold--;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
